// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight; result held until the owning requester accepts.
module alu_arbiter #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [31:0] req_a0,
   input  logic [31:0] req_b0,
   input  logic [31:0] req_a1,
   input  logic [31:0] req_b1,
   input  logic [3:0]  req_f0,
   input  logic [3:0]  req_f1,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_s,
   output logic        rsp_z,
   output logic        rsp_c,
   output logic        rsp_o,
   output logic        rsp_err,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_f,
   input  logic [31:0] alu_s,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_o,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic        r_gnt;
   logic [31:0] r_alu_a;
   logic [31:0] r_alu_b;
   logic [3:0]  r_alu_f;
   logic [31:0] r_rsp_s;
   logic        r_rsp_z;
   logic        r_rsp_c;
   logic        r_rsp_o;
   logic        r_rsp_err;

   logic        w_sel;
   logic        w_xfer;
   logic        w_legal;
   logic        w_logic;
   logic        w_done;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [3:0]  w_f;

   // With both requesting, the one not served last wins; r_gnt resets to 1.
   always_comb begin
      w_sel   = (&req_valid) ? ~r_gnt : ~req_valid[0];
      w_xfer  = (r_state == S_IDLE) && (|req_valid) && !rst;
      w_a     = w_sel ? req_a1 : req_a0;
      w_b     = w_sel ? req_b1 : req_b0;
      w_f     = w_sel ? req_f1 : req_f0;
      w_legal = w_f[3] ^ w_f[2];
      w_logic = (r_alu_f[3:2] == 2'b10);
      w_done  = (r_state == S_EXEC) && (r_cnt == LP_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_xfer) begin
               w_next = w_legal ? S_EXEC : S_RESP;
            end
         end
         S_EXEC: begin
            if (w_done) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready[r_gnt]) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_gnt     <= 1'b1;
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_f   <= '0;
         r_rsp_s   <= '0;
         r_rsp_z   <= 1'b0;
         r_rsp_c   <= 1'b0;
         r_rsp_o   <= 1'b0;
         r_rsp_err <= 1'b0;
      end else if (w_xfer) begin
         r_cnt   <= '0;
         r_gnt   <= w_sel;
         r_alu_a <= w_a;
         r_alu_b <= w_b;
         r_alu_f <= w_f;
         if (!w_legal) begin
            r_rsp_s   <= '0;
            r_rsp_z   <= 1'b0;
            r_rsp_c   <= 1'b0;
            r_rsp_o   <= 1'b0;
            r_rsp_err <= 1'b1;
         end
      end else if (r_state == S_EXEC) begin
         r_cnt <= r_cnt + 4'd1;
         if (w_done) begin
            r_rsp_s   <= alu_s;
            r_rsp_z   <= alu_z;
            r_rsp_c   <= alu_c & ~w_logic;
            r_rsp_o   <= alu_o & ~w_logic;
            r_rsp_err <= 1'b0;
         end
      end
   end

   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      if (w_xfer) begin
         req_ready = w_sel ? 2'b10 : 2'b01;
      end
      if (r_state == S_RESP) begin
         rsp_valid = r_gnt ? 2'b10 : 2'b01;
      end
      busy    = (r_state != S_IDLE);
      alu_a   = r_alu_a;
      alu_b   = r_alu_b;
      alu_f   = r_alu_f;
      rsp_s   = r_rsp_s;
      rsp_z   = r_rsp_z;
      rsp_c   = r_rsp_c;
      rsp_o   = r_rsp_o;
      rsp_err = r_rsp_err;
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

   localparam int SETTLE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [3:0]  req_f0, req_f1;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [31:0] rsp_s;
   logic        rsp_z, rsp_c, rsp_o, rsp_err;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_f;
   logic [31:0] alu_s;
   logic        alu_z, alu_c, alu_o;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   alu_arbiter #(.SETTLE(SETTLE)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0),
      .req_a1(req_a1), .req_b1(req_b1),
      .req_f0(req_f0), .req_f1(req_f1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_c(rsp_c),
      .rsp_o(rsp_o), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
      .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c),
      .alu_o(alu_o), .busy(busy)
   );

   always #5 clk = ~clk;

   // External ALU: returns {c, o, s}; logic ops deliberately return c=o=1.
   function automatic logic [33:0] alu_fn(
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      logic [32:0] t;
      logic [31:0] s;
      logic        c, o;
      t = '0; s = '0; c = 1'b0; o = 1'b0;
      case (f[3:2])
         2'b01: begin
            if (f[0]) t = {1'b0, a} - {1'b0, b};
            else      t = {1'b0, a} + {1'b0, b};
            s = t[31:0];
            c = t[32];
            if (f[0]) o = (a[31] != b[31]) && (s[31] != a[31]);
            else      o = (a[31] == b[31]) && (s[31] != a[31]);
         end
         2'b10: begin
            case (f[1:0])
               2'b00:   s = a & b;
               2'b01:   s = a | b;
               2'b10:   s = a ^ b;
               default: s = ~(a | b);
            endcase
            c = 1'b1;
            o = 1'b1;
         end
         default: begin
            s = a ^ b ^ 32'hdead_beef;
            c = 1'b1;
            o = 1'b1;
         end
      endcase
      return {c, o, s};
   endfunction

   logic [33:0] alu_r;
   always_comb begin
      alu_r = alu_fn(alu_a, alu_b, alu_f);
      alu_s = alu_r[31:0];
      alu_o = alu_r[32];
      alu_c = alu_r[33];
      alu_z = (alu_r[31:0] == 32'd0);
   end

   // Model state: one outstanding op, cycle its response appears, results.
   bit          m_init = 0;
   bit          m_out  = 0;
   bit          m_who  = 0;
   bit          m_last = 1;
   int          m_start = 0;
   logic [31:0] m_alu_a = 0, m_alu_b = 0;
   logic [3:0]  m_alu_f = 0;
   logic [35:0] m_exp  = 0;
   logic [35:0] m_prev = 0;

   logic [1:0]  s_req_ready, s_rsp_valid;
   logic [31:0] s_rsp_s, s_alu_a;
   logic        s_z, s_c, s_o, s_err, s_busy;

   task automatic chk(input string nm, input logic [35:0] act,
                      input logic [35:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [35:0] model_rsp(
      input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      logic [33:0] r;
      bit          arith;
      r = alu_fn(a, b, f);
      arith = (f[3:2] == 2'b01);
      if (f[3:2] == 2'b01 || f[3:2] == 2'b10)
         return {1'b0, arith & r[33], arith & r[32],
                 (r[31:0] == 32'd0), r[31:0]};
      return {1'b1, 3'b000, 32'd0};
   endfunction

   // Compare at negedge against the model, then advance the model one cycle.
   task automatic tick();
      logic [1:0]  e_rdy, e_vld;
      logic [35:0] e_rsp;
      bit          w, showing;
      @(negedge clk);
      s_req_ready = req_ready; s_rsp_valid = rsp_valid;
      s_rsp_s = rsp_s; s_z = rsp_z; s_c = rsp_c; s_o = rsp_o;
      s_err = rsp_err; s_busy = busy; s_alu_a = alu_a;
      w = (&req_valid) ? !m_last : !req_valid[0];
      e_rdy = 2'b00;
      if (!rst && !m_out && (|req_valid)) e_rdy = w ? 2'b10 : 2'b01;
      showing = m_out && (cyc >= m_start);
      e_vld = showing ? (m_who ? 2'b10 : 2'b01) : 2'b00;
      e_rsp = showing ? m_exp : m_prev;
      if (m_init) begin
         chk("req_ready", 36'(req_ready), 36'(e_rdy));
         chk("rsp_valid", 36'(rsp_valid), 36'(e_vld));
         chk("busy", 36'(busy), 36'(m_out));
         chk("rsp_bundle", {rsp_err, rsp_c, rsp_o, rsp_z, rsp_s}, e_rsp);
         chk("alu_ports", {alu_f, alu_a}, {m_alu_f, m_alu_a});
         chk("alu_b", 36'(alu_b), 36'(m_alu_b));
      end
      if (rst) begin
         m_init = 1; m_out = 0; m_last = 1;
         m_alu_a = 0; m_alu_b = 0; m_alu_f = 0; m_prev = 0;
      end else if (e_rdy != 2'b00) begin
         m_out = 1; m_who = w; m_last = w;
         m_alu_a = w ? req_a1 : req_a0;
         m_alu_b = w ? req_b1 : req_b0;
         m_alu_f = w ? req_f1 : req_f0;
         m_exp = model_rsp(m_alu_a, m_alu_b, m_alu_f);
         m_start = cyc + 1 +
                   ((m_alu_f[3] ^ m_alu_f[2]) ? SETTLE : 0);
      end else if (showing && rsp_ready[m_who]) begin
         m_out = 0;
         m_prev = m_exp;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
      tick();
      rst = 1'b0;
   endtask

   // Model self-pins against hand-computed values.
   initial begin
      logic [35:0] r;
      r = model_rsp(32'd5, 32'd3, 4'b0100);
      chk("pin_add", r, {4'b0000, 32'd8});
      r = model_rsp(32'hffff_ffff, 32'd1, 4'b0100);
      chk("pin_carry", r, {4'b0101, 32'd0});
      r = model_rsp(32'h0f, 32'hf0, 4'b1000);
      chk("pin_logic", r, {4'b0001, 32'd0});
   end

   initial begin
      logic [1:0] grants[$];
      req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
      req_f0 = 0; req_f1 = 0;
      @(posedge clk); #1;
      do_reset();
      chk("reset_busy", 36'(s_busy), 36'd0);

      // add on requester 0
      req_valid = 2'b01; req_a0 = 5; req_b0 = 3; req_f0 = 4'b0100;
      rsp_ready = 2'b01;
      tick();
      chk("add_grant", 36'(s_req_ready), 36'd1);
      req_valid = 2'b00;
      tick(); tick(); tick();
      chk("add_rsp_valid", 36'(s_rsp_valid), 36'd1);
      chk("add_sum", 36'(s_rsp_s), 36'd8);
      chk("add_err", 36'(s_err), 36'd0);

      // illegal function on requester 1
      req_valid = 2'b10; req_a1 = 32'h1234; req_b1 = 7; req_f1 = 4'b0000;
      rsp_ready = 2'b10;
      tick();
      chk("ill_grant", 36'(s_req_ready), 36'd2);
      req_valid = 2'b00;
      tick();
      chk("ill_rsp", {s_err, s_rsp_valid, s_rsp_s}, {1'b1, 2'b10, 32'd0});
      tick();

      // logic op with ALU reporting c=o=1
      req_valid = 2'b01; req_a0 = 32'h0f; req_b0 = 32'hf0;
      req_f0 = 4'b1000; rsp_ready = 2'b01;
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick();
      chk("logic_flags", {s_rsp_valid, s_c, s_o, s_z}, {2'b01, 3'b001});

      // response held 10 cycles with the other ready bit set
      req_valid = 2'b10; req_a1 = 9; req_b1 = 4; req_f1 = 4'b0101;
      rsp_ready = 2'b01;
      tick();
      req_valid = 2'b11;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold", {s_req_ready, s_rsp_valid, s_rsp_s},
             {2'b00, 2'b10, 32'd5});
      end
      req_valid = 2'b00; rsp_ready = 2'b10;
      tick();
      rsp_ready = 2'b00;
      tick();
      chk("hold_exit", 36'(s_busy), 36'd0);

      // reset mid-EXEC discards the op
      req_valid = 2'b10; req_f1 = 4'b0100;
      tick();
      req_valid = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0; rsp_ready = 2'b11;
      tick();
      chk("rst_exec", {s_busy, s_rsp_valid, s_alu_a}, {3'b000, 32'd0});
      req_valid = 2'b11; req_f0 = 4'b0100;
      tick();
      chk("rst_next_grant", 36'(s_req_ready), 36'd1);

      // continuous contention alternates 0,1,0,1 after reset
      do_reset();
      req_valid = 2'b11; rsp_ready = 2'b11;
      req_f0 = 4'b0101; req_f1 = 4'b1001;
      for (int i = 0; i < 4 * (SETTLE + 2); i++) begin
         tick();
         if (s_req_ready != 2'b00) grants.push_back(s_req_ready);
      end
      chk("rr_count", 36'(grants.size()), 36'd4);
      if (grants.size() >= 4)
         chk("rr_seq", 36'({grants[0], grants[1], grants[2], grants[3]}),
             36'({2'b01, 2'b10, 2'b01, 2'b10}));

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         req_valid = 2'($urandom);
         rsp_ready = 2'($urandom);
         req_a0 = $urandom; req_b0 = $urandom;
         req_a1 = $urandom; req_b1 = $urandom;
         if ($urandom_range(0, 3) == 0) req_b0 = req_a0;
         req_f0 = 4'($urandom); req_f1 = 4'($urandom);
         tick();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
